// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader state encoding and the NOP instruction word.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/im_loader_if.sv
// Host program stream plus instruction-memory write port of the loader.
interface im_loader_if #(
   parameter int AW = 5
) ();

   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_last;
   logic          in_ready;
   logic          im_we;
   logic [AW-1:0] im_waddr;
   logic [31:0]   im_wdata;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready, im_we, im_waddr, im_wdata
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready, im_we, im_waddr, im_wdata
   );

endinterface

// File: rtl/im_loader.sv
// Clears instruction memory to NOPs, streams a host program into it, then releases the CPU.
module im_loader
   import cpu_pkg::*;
#(
   parameter int NMEM = 20,
   parameter int AW   = $clog2(NMEM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   im_loader_if.master   bus,
   output logic          cpu_run,
   output logic          done,
   output logic          err,
   output logic [AW:0]   word_count
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(NMEM - 1);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_e        r_state;
   logic [AW:0]   r_cnt;
   logic          r_in_ready;
   logic          r_im_we;
   logic [AW-1:0] r_im_waddr;
   logic [31:0]   r_im_wdata;
   logic          r_cpu_run;
   logic          r_done;
   logic          r_err;
   logic          w_hs;
   logic          w_last_slot;

   assign w_hs        = bus.in_valid & r_in_ready;
   assign w_last_slot = (r_cnt == LAST_IDX);

   // Loader FSM; r_cnt is the clear address in CLEAR and the accepted-word count in LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_in_ready <= 1'b0;
         r_im_we    <= 1'b0;
         r_im_waddr <= '0;
         r_im_wdata <= 32'h0000_0000;
         r_cpu_run  <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_im_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               r_im_we    <= 1'b1;
               r_im_waddr <= r_cnt[AW-1:0];
               r_im_wdata <= NOP_WORD;
               if (w_last_slot) begin
                  r_state    <= ST_LOAD;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + ONE;
               end
            end
            ST_LOAD: begin
               if (w_hs) begin
                  r_im_we    <= 1'b1;
                  r_im_waddr <= r_cnt[AW-1:0];
                  r_im_wdata <= bus.in_data;
                  r_cnt      <= r_cnt + ONE;
                  if (bus.in_last) begin
                     r_state    <= ST_RUN;
                     r_in_ready <= 1'b0;
                  end else if (w_last_slot) begin
                     r_state    <= ST_ERR;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            // Status rises one cycle after entry so it follows the final memory write
            ST_RUN: begin
               if (start) begin
                  r_state   <= ST_CLEAR;
                  r_cnt     <= '0;
                  r_cpu_run <= 1'b0;
                  r_done    <= 1'b0;
               end else begin
                  r_cpu_run <= 1'b1;
                  r_done    <= 1'b1;
               end
            end
            ST_ERR: begin
               if (start) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
               end else begin
                  r_err <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_cnt      <= '0;
               r_in_ready <= 1'b0;
               r_cpu_run  <= 1'b0;
               r_done     <= 1'b0;
               r_err      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = r_in_ready;
   assign bus.im_we    = r_im_we;
   assign bus.im_waddr = r_im_waddr;
   assign bus.im_wdata = r_im_wdata;
   assign cpu_run      = r_cpu_run;
   assign done         = r_done;
   assign err          = r_err;
   // While clearing, the register holds a clear address, not an accepted-word count
   assign word_count   = (r_state == ST_CLEAR) ? '0 : r_cnt;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected memory writes are queued at stimulus time.
module tb_im_loader;

   localparam int NMEM = 20;
   localparam int AW   = $clog2(NMEM);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cpu_run, done, err;
   logic [AW:0] word_count;

   im_loader_if #(.AW(AW)) bus ();

   im_loader #(.NMEM(NMEM), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .cpu_run(cpu_run), .done(done), .err(err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] mem [NMEM];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          n_writes = 0;
   int          exp_cnt = 0;

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus.im_we === 1'b1) begin
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_mis++;
               $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.im_waddr, bus.im_wdata);
            end else begin
               e = exp_q.pop_front();
               if (bus.im_waddr !== e.addr || bus.im_wdata !== e.data) begin
                  n_mis++;
                  $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", bus.im_waddr, bus.im_wdata, e.addr, e.data);
               end
            end
            if (int'(bus.im_waddr) < NMEM) mem[bus.im_waddr] = bus.im_wdata;
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < NMEM; i++) exp_q.push_back({AW'(i), 32'h0000_0000});
      exp_cnt = 0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL %s_drain: got %0d pending writes, required 0", name, exp_q.size());
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      bit rdy = 1'b0;
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (ok) begin
         exp_q.push_back({AW'(exp_cnt), d});
         exp_cnt++;
      end else begin
         n_cmp++;
         n_mis++;
         $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles, required 1");
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0000_0000;
      bus.in_last  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.im_we, bus.im_waddr, bus.im_wdata, cpu_run, done, err, word_count} !== '0) begin
         n_mis++;
         $display("FAIL reset_outputs: got rdy=%b we=%b a=%0d d=%h run=%b done=%b err=%b wc=%0d, required all 0",
                  bus.in_ready, bus.im_we, bus.im_waddr, bus.im_wdata, cpu_run, done, err, word_count);
      end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || cpu_run !== 1'b0 || n_writes != 0) begin
         n_mis++;
         $display("FAIL reset_no_autostart: got rdy=%b run=%b writes=%0d, required 0/0/0", bus.in_ready, cpu_run, n_writes);
      end
   endtask

   task automatic test_basic();
      pulse_start();
      wait_drain("basic_clear");
      send_word(32'h2001_0005, 1'b0);
      send_word(32'h2002_0003, 1'b0);
      send_word(32'h0022_1820, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (bus.im_we !== 1'b1 || cpu_run !== 1'b0) begin
         n_mis++;
         $display("FAIL basic_last_write: got we=%b run=%b, required we=1 run=0", bus.im_we, cpu_run);
      end
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b1 || done !== 1'b1 || bus.im_we !== 1'b0 || word_count !== (AW+1)'(3)) begin
         n_mis++;
         $display("FAIL basic_run: got run=%b done=%b we=%b wc=%0d, required 1/1/0/3", cpu_run, done, bus.im_we, word_count);
      end
      n_cmp++;
      if (mem[0] !== 32'h2001_0005 || mem[1] !== 32'h2002_0003 || mem[2] !== 32'h0022_1820) begin
         n_mis++;
         $display("FAIL basic_mem_prog: got %h %h %h, required 20010005 20020003 00221820", mem[0], mem[1], mem[2]);
      end
      for (int i = 3; i < NMEM; i++) begin
         n_cmp++;
         if (mem[i] !== 32'h0000_0000) begin
            n_mis++;
            $display("FAIL basic_mem_nop: got mem[%0d]=%h, required 00000000", i, mem[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_restart_from_run();
      pulse_start();
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b0 || done !== 1'b0) begin
         n_mis++;
         $display("FAIL restart_drop: got run=%b done=%b, required 0/0", cpu_run, done);
      end
      wait_drain("restart_clear");
      n_cmp++;
      if (mem[0] !== 32'h0000_0000) begin
         n_mis++;
         $display("FAIL restart_clear0: got mem[0]=%h, required 00000000", mem[0]);
      end
      send_word(32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b1 || word_count !== (AW+1)'(1)) begin
         n_mis++;
         $display("FAIL restart_run: got run=%b wc=%0d, required 1/1", cpu_run, word_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_toggle();
      int w0;
      pulse_start();
      wait_drain("toggle_clear");
      w0 = n_writes;
      for (int i = 0; i < 4; i++) begin
         send_word(32'hA5A5_0000 + 32'(i), (i == 3));
         if (i < 3) begin
            bus.in_data = 32'hBAD0_0000 + 32'(i);
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b1 || word_count !== (AW+1)'(4) || (n_writes - w0) != 4) begin
         n_mis++;
         $display("FAIL toggle_result: got run=%b wc=%0d writes=%0d, required 1/4/4", cpu_run, word_count, n_writes - w0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      pulse_start();
      wait_drain("ovf_clear");
      for (int i = 0; i < NMEM; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h7777_7777;
      @(negedge clk);
      n_cmp++;
      if (bus.im_we !== 1'b1 || err !== 1'b0) begin
         n_mis++;
         $display("FAIL ovf_last_write: got we=%b err=%b, required 1/0", bus.im_we, err);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1 || cpu_run !== 1'b0 || done !== 1'b0 || word_count !== (AW+1)'(NMEM) || bus.in_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL ovf_err: got err=%b run=%b done=%b wc=%0d rdy=%b, required 1/0/0/20/0", err, cpu_run, done, word_count, bus.in_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || word_count !== (AW+1)'(NMEM)) begin
         n_mis++;
         $display("FAIL ovf_hold: got err=%b wc=%0d, required 1/20", err, word_count);
      end
   endtask

   task automatic test_start_in_clear();
      int w0;
      w0 = n_writes;
      pulse_start();
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0) begin
         n_mis++;
         $display("FAIL clr_err_drop: got err=%b, required 0", err);
      end
      repeat (3) @(posedge clk);
      #1;
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      bus.in_data  = 32'hFFFF_FFFF;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL clr_ready: got in_ready=%b, required 0", bus.in_ready);
      end
      repeat (4) @(posedge clk);
      #1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      wait_drain("clr_clear");
      n_cmp++;
      if ((n_writes - w0) != NMEM) begin
         n_mis++;
         $display("FAIL clr_count: got %0d writes, required %0d", n_writes - w0, NMEM);
      end
      send_word(32'h0000_1111, 1'b1);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b1 || word_count !== (AW+1)'(1)) begin
         n_mis++;
         $display("FAIL clr_run: got run=%b wc=%0d, required 1/1", cpu_run, word_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_load();
      int w0;
      pulse_start();
      wait_drain("rml_clear");
      send_word(32'h0ABC_0001, 1'b0);
      send_word(32'h0ABC_0002, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.im_we, bus.im_waddr, bus.im_wdata, cpu_run, done, err, word_count} !== '0) begin
         n_mis++;
         $display("FAIL rml_async: got rdy=%b we=%b a=%0d d=%h run=%b wc=%0d, required all 0",
                  bus.in_ready, bus.im_we, bus.im_waddr, bus.im_wdata, cpu_run, word_count);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL rml_pending: got %0d pending writes, required 0", exp_q.size());
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      w0 = n_writes;
      bus.in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || cpu_run !== 1'b0 || word_count !== '0 || n_writes != w0) begin
         n_mis++;
         $display("FAIL rml_idle: got rdy=%b run=%b wc=%0d writes=%0d, required 0/0/0/0", bus.in_ready, cpu_run, word_count, n_writes - w0);
      end
      pulse_start();
      wait_drain("rml_reclear");
      send_word(32'h0ABC_0003, 1'b1);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (cpu_run !== 1'b1 || word_count !== (AW+1)'(1) || mem[0] !== 32'h0ABC_0003 || mem[1] !== 32'h0000_0000) begin
         n_mis++;
         $display("FAIL rml_resume: got run=%b wc=%0d m0=%h m1=%h, required 1/1/0abc0003/00000000", cpu_run, word_count, mem[0], mem[1]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_restart_from_run();
      test_toggle();
      test_overflow();
      test_start_in_clear();
      test_reset_mid_load();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
